// File: rtl/mpsoc_msi_ahb_pkg.sv
// rtl/mpsoc_msi_ahb_pkg.sv - AHB-Lite encodings, arbiter state type and burst length helper
package mpsoc_msi_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_BURST = 2'd2,
        ARB_LOCK  = 2'd3
    } arb_state_t;

    // Beats still to come after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
            default:                      burst_beats = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/mpsoc_msi_rr_prio_select.sv
// rtl/mpsoc_msi_rr_prio_select.sv - combinational highest-priority pick with round-robin tie-break
module mpsoc_msi_rr_prio_select #(
    parameter int N  = 5,
    parameter int PW = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0][PW-1:0] prio,
    input  logic [IW-1:0]        ptr,
    output logic [N-1:0]         winner,
    output logic [IW-1:0]        winner_idx,
    output logic                 found
);

    // Scan in round-robin order starting just after ptr; only a strictly higher
    // priority displaces the current pick, so ties go to the earliest in that order.
    always_comb begin
        int            pos;
        logic [IW-1:0] cand;
        logic [PW-1:0] best;
        pos        = 0;
        cand       = '0;
        best       = '0;
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int k = 1; k <= N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = IW'(pos);
            if (req[cand] && (!found || prio[cand] > best)) begin
                found      = 1'b1;
                best       = prio[cand];
                winner_idx = cand;
            end
        end
        winner[winner_idx] = found;
    end

endmodule

// File: rtl/mpsoc_msi_ahb_slave_arbiter.sv
// rtl/mpsoc_msi_ahb_slave_arbiter.sv - per-slave AHB-Lite arbiter with burst/lock hold and data-phase tracking
// Optional starvation timeout: define MPSOC_MSI_STARVATION_TIMEOUT_EN.
module mpsoc_msi_ahb_slave_arbiter
    import mpsoc_msi_ahb_pkg::*;
#(
    parameter int MASTERS = 5,
    parameter int PRIO_W  = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [MASTERS-1:0][PRIO_W-1:0]   mst_priority,
    input  logic [MASTERS-1:0]               mst_HSEL,
    input  logic [MASTERS-1:0][1:0]          mst_HTRANS,
    input  logic [MASTERS-1:0][2:0]          mst_HBURST,
    input  logic [MASTERS-1:0]               mst_HMASTLOCK,
    input  logic                             slv_HREADY,
    output logic [MASTERS-1:0]               grant,
    output logic [$clog2(MASTERS)-1:0]       grant_idx,
    output logic                             grant_valid,
    output logic [MASTERS-1:0]               dphase_owner,
    output logic                             dphase_valid,
    output logic                             locked
);

    localparam int IW = $clog2(MASTERS);

    if (MASTERS < 2 || TIMEOUT < 2) begin : g_bad_params
        $error("mpsoc_msi_ahb_slave_arbiter: MASTERS and TIMEOUT must be >= 2");
    end

    logic [MASTERS-1:0] req;
    arb_state_t         state, state_n;
    logic [3:0]         beat_cnt, beat_n;
    logic [IW-1:0]      rr_ptr;
    logic               hold;

    logic [1:0]         own_trans;
    logic [2:0]         own_burst;
    logic               own_lock;
    logic               own_sel;

    logic [MASTERS-1:0] pw_win;
    logic [IW-1:0]      pw_idx;
    logic               pw_any;
    logic [MASTERS-1:0] win;
    logic [IW-1:0]      win_idx;
    logic               win_any;

    for (genvar g = 0; g < MASTERS; g++) begin : g_req
        assign req[g] = mst_HSEL[g] & (mst_HTRANS[g] == HTRANS_NONSEQ);
    end

    assign own_trans = mst_HTRANS[grant_idx];
    assign own_burst = mst_HBURST[grant_idx];
    assign own_lock  = mst_HMASTLOCK[grant_idx];
    assign own_sel   = mst_HSEL[grant_idx];

    mpsoc_msi_rr_prio_select #(
        .N  (MASTERS),
        .PW (PRIO_W),
        .IW (IW)
    ) u_prio_sel (
        .req        (req),
        .prio       (mst_priority),
        .ptr        (rr_ptr),
        .winner     (pw_win),
        .winner_idx (pw_idx),
        .found      (pw_any)
    );

`ifdef MPSOC_MSI_STARVATION_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [MASTERS-1:0][CW-1:0] wait_cnt;
    logic [MASTERS-1:0]         starved;
    logic [MASTERS-1:0]         st_win;
    logic [IW-1:0]              st_idx;
    logic                       st_any;

    for (genvar g = 0; g < MASTERS; g++) begin : g_wait
        assign starved[g] = (wait_cnt[g] == CW'(TIMEOUT));

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                wait_cnt[g] <= '0;
            end else if (req[g] && !grant[g]) begin
                if (!starved[g]) begin
                    wait_cnt[g] <= wait_cnt[g] + 1'b1;
                end
            end else begin
                wait_cnt[g] <= '0;
            end
        end
    end

    // Saturated requesters outrank every priority level and share the RR pointer.
    mpsoc_msi_rr_prio_select #(
        .N  (MASTERS),
        .PW (PRIO_W),
        .IW (IW)
    ) u_starve_sel (
        .req        (req & starved),
        .prio       ('0),
        .ptr        (rr_ptr),
        .winner     (st_win),
        .winner_idx (st_idx),
        .found      (st_any)
    );

    assign win     = st_any ? st_win : pw_win;
    assign win_idx = st_any ? st_idx : pw_idx;
    assign win_any = st_any | pw_any;
`else
    assign win     = pw_win;
    assign win_idx = pw_idx;
    assign win_any = pw_any;
`endif

    // Decide whether the current owner keeps the address phase at this arbitration point.
    always_comb begin
        hold    = 1'b0;
        state_n = state;
        beat_n  = beat_cnt;
        if (grant_valid && own_lock && own_sel) begin
            hold    = 1'b1;
            state_n = ARB_LOCK;
            beat_n  = '0;
        end else if (grant_valid && state == ARB_BURST) begin
            if (own_trans == HTRANS_SEQ && beat_cnt > 4'd1) begin
                hold   = 1'b1;
                beat_n = beat_cnt - 4'd1;
            end else if (own_trans == HTRANS_BUSY) begin
                hold = 1'b1;
            end
        end else if (grant_valid && own_trans == HTRANS_NONSEQ && burst_beats(own_burst) != 4'd0) begin
            hold    = 1'b1;
            state_n = ARB_BURST;
            beat_n  = burst_beats(own_burst);
        end else if (grant_valid && own_burst == HBURST_INCR &&
                     (own_trans == HTRANS_SEQ || own_trans == HTRANS_BUSY)) begin
            hold    = 1'b1;
            state_n = ARB_OWN;
        end
        if (!hold) begin
            beat_n  = '0;
            state_n = win_any ? ARB_OWN : ARB_IDLE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= ARB_IDLE;
            beat_cnt     <= '0;
            rr_ptr       <= IW'(MASTERS - 1);
            grant        <= '0;
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
            dphase_owner <= '0;
            dphase_valid <= 1'b0;
            locked       <= 1'b0;
        end else if (slv_HREADY) begin
            state    <= state_n;
            beat_cnt <= beat_n;
            locked   <= (state_n == ARB_LOCK) || (state_n == ARB_BURST);
            if (!hold) begin
                if (win_any) begin
                    grant       <= win;
                    grant_idx   <= win_idx;
                    grant_valid <= 1'b1;
                    rr_ptr      <= win_idx;
                end else begin
                    grant_valid <= 1'b0;
                end
            end
            if (grant_valid && own_trans[1]) begin
                dphase_owner <= grant;
                dphase_valid <= 1'b1;
            end else begin
                dphase_owner <= '0;
                dphase_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mpsoc_msi_ahb_slave_arbiter.sv
// tb/tb_mpsoc_msi_ahb_slave_arbiter.sv - directed and randomized checks of the slave arbiter against a behavioural model
module tb_mpsoc_msi_ahb_slave_arbiter;

    localparam int M  = 5;
    localparam int PW = 3;
    localparam int TO = 8;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [M-1:0][PW-1:0]  prio;
    logic [M-1:0]          hsel;
    logic [M-1:0][1:0]     htrans;
    logic [M-1:0][2:0]     hburst;
    logic [M-1:0]          hlock;
    logic                  rdy;

    logic [M-1:0]          grant;
    logic [2:0]            grant_idx;
    logic                  grant_valid;
    logic [M-1:0]          dphase_owner;
    logic                  dphase_valid;
    logic                  locked;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mpsoc_msi_ahb_slave_arbiter #(
        .MASTERS (M),
        .PRIO_W  (PW),
        .TIMEOUT (TO)
    ) dut (
        .HCLK          (clk),
        .HRESET        (rst),
        .mst_priority  (prio),
        .mst_HSEL      (hsel),
        .mst_HTRANS    (htrans),
        .mst_HBURST    (hburst),
        .mst_HMASTLOCK (hlock),
        .slv_HREADY    (rdy),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .grant_valid   (grant_valid),
        .dphase_owner  (dphase_owner),
        .dphase_valid  (dphase_valid),
        .locked        (locked)
    );

    // Reference model: owner index, hold reason (0 none, 1 owned, 2 fixed burst, 3 lock), beats still due
    int          mo_idx;
    bit          mo_valid;
    int          mo_mode;
    int          mo_left;
    int          mo_ptr;
    bit [M-1:0]  mo_grant;
    bit [M-1:0]  mo_dph;
    bit          mo_dphv;
    bit          mo_locked;
    int          mo_wait [M];

    function automatic int pick_winner(input logic [M-1:0] r, input int eff [M], input int ptr);
        int best;
        int c;
        best = -1;
        for (int i = 0; i < M; i++) begin
            if (r[i] && eff[i] > best) best = eff[i];
        end
        if (best < 0) return -1;
        for (int k = 1; k <= M; k++) begin
            c = (ptr + k) % M;
            if (r[c] && eff[c] == best) return c;
        end
        return -1;
    endfunction

    function automatic void model_step();
        logic [M-1:0] r;
        int           eff [M];
        int           w;
        int           o;
        int           nmode;
        int           nleft;
        bit           keep;
        logic [1:0]   t;
        if (rst) begin
            mo_idx = 0; mo_valid = 0; mo_mode = 0; mo_left = 0; mo_ptr = M - 1;
            mo_grant = '0; mo_dph = '0; mo_dphv = 0; mo_locked = 0;
            for (int i = 0; i < M; i++) mo_wait[i] = 0;
            return;
        end
        for (int i = 0; i < M; i++) begin
            r[i]   = hsel[i] && (htrans[i] == T_NONSEQ);
            eff[i] = int'(prio[i]);
        end
`ifdef MPSOC_MSI_STARVATION_TIMEOUT_EN
        for (int i = 0; i < M; i++) begin
            if (mo_wait[i] == TO) eff[i] = 1 << PW;
        end
        for (int i = 0; i < M; i++) begin
            if (r[i] && !mo_grant[i]) mo_wait[i] = (mo_wait[i] < TO) ? mo_wait[i] + 1 : TO;
            else mo_wait[i] = 0;
        end
`endif
        if (!rdy) return;
        o = mo_idx;
        t = htrans[o];
        keep = 0; nmode = mo_mode; nleft = mo_left;
        if (mo_valid) begin
            if (hlock[o] && hsel[o]) begin
                keep = 1; nmode = 3; nleft = 0;
            end else if (mo_mode == 2) begin
                if (t == T_SEQ && mo_left > 1) begin
                    keep = 1; nleft = mo_left - 1;
                end else if (t == T_BUSY) begin
                    keep = 1;
                end
            end else if (t == T_NONSEQ && hburst[o] >= 3'd2) begin
                keep = 1; nmode = 2;
                nleft = (hburst[o] >= 3'd6) ? 15 : (hburst[o] >= 3'd4) ? 7 : 3;
            end else if (hburst[o] == 3'd1 && (t == T_SEQ || t == T_BUSY)) begin
                keep = 1; nmode = 1;
            end
        end
        if (mo_valid && t[1]) begin
            mo_dph = mo_grant; mo_dphv = 1;
        end else begin
            mo_dph = '0; mo_dphv = 0;
        end
        if (keep) begin
            mo_mode = nmode; mo_left = nleft;
        end else begin
            mo_left = 0;
            w = pick_winner(r, eff, mo_ptr);
            if (w >= 0) begin
                mo_mode = 1; mo_idx = w; mo_valid = 1; mo_ptr = w;
                mo_grant = '0; mo_grant[w] = 1'b1;
            end else begin
                mo_mode = 0; mo_valid = 0;
            end
        end
        mo_locked = (mo_mode == 2) || (mo_mode == 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_all();
        rdy = 1'b1;
        for (int i = 0; i < M; i++) begin
            prio[i] = '0; hsel[i] = 1'b0; htrans[i] = T_IDLE; hburst[i] = 3'd0; hlock[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        for (int i = 0; i < M; i++) begin
            hsel[i] = 1'b1; htrans[i] = T_NONSEQ; prio[i] = PW'(i);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({grant, grant_idx, grant_valid, dphase_owner, dphase_valid, locked} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got grant=%b idx=%0d gv=%b dph=%b dv=%b lk=%b expected all zero",
                     grant, grant_idx, grant_valid, dphase_owner, dphase_valid, locked);
        end
        rst = 1'b0;
        idle_all();
        for (int i = 0; i < M; i++) prio[i] = 3'd3;
        hsel[0] = 1'b1; htrans[0] = T_NONSEQ;
        hsel[2] = 1'b1; htrans[2] = T_NONSEQ;
        tick();
        checks++;
        if (grant !== 5'b00001 || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_tie: got grant=%b idx=%0d gv=%b expected 00001 idx 0 gv 1",
                     grant, grant_idx, grant_valid);
        end
    endtask

    task automatic test_priority();
        do_reset();
        prio[1] = 3'd2; prio[3] = 3'd5;
        hsel[1] = 1'b1; htrans[1] = T_NONSEQ;
        hsel[3] = 1'b1; htrans[3] = T_NONSEQ;
        tick();
        checks++;
        if (grant !== 5'b01000 || grant_idx !== 3'd3) begin
            failures++;
            $display("FAIL priority_pick: got grant=%b idx=%0d expected 01000 idx 3", grant, grant_idx);
        end
        checks++;
        if (grant !== mo_grant) begin
            failures++;
            $display("FAIL priority_model: got %b expected %b", grant, mo_grant);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq [4] = '{0, 1, 2, 0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            prio[i] = 3'd4; hsel[i] = 1'b1; htrans[i] = T_NONSEQ;
        end
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (grant_idx !== 3'(exp_seq[n]) || grant_valid !== 1'b1) begin
                failures++;
                $display("FAIL round_robin step %0d: got idx=%0d gv=%b expected idx=%0d gv=1",
                         n, grant_idx, grant_valid, exp_seq[n]);
            end
        end
    endtask

    task automatic test_burst_hold();
        bit [M-1:0] eg [8] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b10000, 5'b10000};
        bit [M-1:0] ed [8] = '{5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b10000};
        bit         el [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < M; i++) prio[i] = 3'd1;
        prio[4] = 3'd6;
        hsel[2] = 1'b1; hburst[2] = 3'd3;
        for (int s = 0; s < 8; s++) begin
            case (s)
                0, 1: htrans[2] = T_NONSEQ;
                2: begin
                    htrans[2] = T_SEQ;
                    hsel[4] = 1'b1; htrans[4] = T_NONSEQ; hburst[4] = 3'd0;
                end
                3, 4: rdy = 1'b0;
                5: rdy = 1'b1;
                7: begin
                    hsel[2] = 1'b0; htrans[2] = T_IDLE;
                end
                default: ;
            endcase
            tick();
            checks++;
            if (grant !== eg[s] || dphase_owner !== ed[s] || locked !== el[s]) begin
                failures++;
                $display("FAIL burst_hold step %0d: got grant=%b dph=%b lk=%b expected grant=%b dph=%b lk=%b",
                         s, grant, dphase_owner, locked, eg[s], ed[s], el[s]);
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        prio[0] = 3'd7; prio[1] = 3'd1;
        hsel[1] = 1'b1; htrans[1] = T_NONSEQ; hlock[1] = 1'b1;
        tick();
        checks++;
        if (grant !== 5'b00010) begin
            failures++;
            $display("FAIL lock_first_grant: got %b expected 00010", grant);
        end
        hsel[0] = 1'b1; htrans[0] = T_NONSEQ;
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++;
            if (grant !== 5'b00010 || locked !== 1'b1) begin
                failures++;
                $display("FAIL lock_hold xfer %0d: got grant=%b lk=%b expected 00010 lk=1", n, grant, locked);
            end
        end
        hlock[1] = 1'b0; htrans[1] = T_IDLE;
        tick();
        checks++;
        if (grant !== 5'b00001 || locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_release: got grant=%b lk=%b expected 00001 lk=0", grant, locked);
        end
    endtask

    task automatic test_starvation();
        int exp_idx;
        do_reset();
        prio[0] = 3'd0; prio[1] = 3'd7;
        hsel[0] = 1'b1; htrans[0] = T_NONSEQ;
        hsel[1] = 1'b1; htrans[1] = T_NONSEQ;
        for (int c = 1; c <= 20; c++) begin
            tick();
`ifdef MPSOC_MSI_STARVATION_TIMEOUT_EN
            exp_idx = (c <= TO) ? 1 : (c == TO + 1) ? 0 : -1;
`else
            exp_idx = 1;
`endif
            if (exp_idx >= 0) begin
                checks++;
                if (grant_idx !== 3'(exp_idx)) begin
                    failures++;
                    $display("FAIL starvation cycle %0d: got idx=%0d expected %0d", c, grant_idx, exp_idx);
                end
            end
            checks++;
            if (grant !== mo_grant) begin
                failures++;
                $display("FAIL starvation_model cycle %0d: got %b expected %b", c, grant, mo_grant);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            rdy = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < M; i++) prio[i] = PW'($urandom);
            end
            for (int i = 0; i < M; i++) begin
                hsel[i]   = ($urandom_range(0, 3) != 0);
                htrans[i] = 2'($urandom);
                hburst[i] = 3'($urandom);
                hlock[i]  = ($urandom_range(0, 9) == 0);
            end
            if (mo_valid && $urandom_range(0, 3) != 0) begin
                htrans[mo_idx] = ($urandom_range(0, 3) != 0) ? T_SEQ : T_BUSY;
            end
            tick();
            checks++;
            if (grant !== mo_grant) begin
                failures++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, grant, mo_grant);
            end
            checks++;
            if (grant_idx !== 3'(mo_idx)) begin
                failures++; $display("FAIL rnd_grant_idx c%0d: got %0d expected %0d", c, grant_idx, mo_idx);
            end
            checks++;
            if (grant_valid !== mo_valid) begin
                failures++; $display("FAIL rnd_grant_valid c%0d: got %b expected %b", c, grant_valid, mo_valid);
            end
            checks++;
            if (dphase_owner !== mo_dph) begin
                failures++; $display("FAIL rnd_dphase_owner c%0d: got %b expected %b", c, dphase_owner, mo_dph);
            end
            checks++;
            if (dphase_valid !== mo_dphv) begin
                failures++; $display("FAIL rnd_dphase_valid c%0d: got %b expected %b", c, dphase_valid, mo_dphv);
            end
            checks++;
            if (locked !== mo_locked) begin
                failures++; $display("FAIL rnd_locked c%0d: got %b expected %b", c, locked, mo_locked);
            end
        end
    endtask

    initial begin
        idle_all();
        rst = 1'b1;
        test_reset();
        test_priority();
        test_round_robin();
        test_burst_hold();
        test_lock();
        test_starvation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
